// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_forward_select.sv
// Per-operand forwarding select: MEM result beats WB result beats register file.
// Purely combinational, zero latency.
// No backpressure; x0 is never forwarded.
module forward_select
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output fwd_sel_t         sel
);

  // Priority compare: the younger MEM-stage value wins over WB
  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && (mem_rd == rs) && (rs != '0)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd == rs) && (rs != '0)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding selects plus stall/flush sequencing for the 5-stage core.
// Stall/flush/md_done are combinational from registered state and current inputs (no added latency).
// Memory wait stalls until mem_ready; mul/div stalls exactly MD_LATENCY cycles; load-use inserts one bubble.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_W-1:0]       id_rs1,
  input  logic [REG_W-1:0]       id_rs2,
  input  logic [REG_W-1:0]       ex_rs1,
  input  logic [REG_W-1:0]       ex_rs2,
  input  logic [REG_W-1:0]       ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_md_start,
  input  logic                   ex_branch_taken,
  input  logic [REG_W-1:0]       mem_rd,
  input  logic [REG_W-1:0]       wb_rd,
  input  logic                   mem_reg_write,
  input  logic                   wb_reg_write,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   stall_e,
  output logic                   stall_m,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic                   flush_m,
  output logic                   flush_w,
  output logic                   md_done,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int MD_W = $clog2(MD_LATENCY);
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LATENCY - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_PRE  = TO_W'(MEM_TIMEOUT - 1);

  hz_state_t       state;
  logic [MD_W-1:0] md_cnt;
  logic [TO_W-1:0] to_cnt;
  fwd_sel_t        fwd_a;
  fwd_sel_t        fwd_b;
  logic            load_use;
  logic            mem_miss;

  forward_select u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a)
  );

  forward_select u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b)
  );

  assign fwd_a_sel = fwd_a;
  assign fwd_b_sel = fwd_b;

  assign load_use = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign mem_miss = mem_req && !mem_ready;

  // Stall/flush decode; everything forced low while reset is held
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    md_done = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_miss) begin
            {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
          end else if (ex_md_start) begin
            {stall_f, stall_d, stall_e, flush_m} = 4'b1111;
          end else if (ex_branch_taken) begin
            {flush_d, flush_e} = 2'b11;
          end else if (load_use) begin
            {stall_f, stall_d, flush_e} = 3'b111;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
          end
        end
        MD_WAIT: begin
          if (md_cnt != '0) begin
            {stall_f, stall_d, stall_e, flush_m} = 4'b1111;
          end else begin
            md_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, wait counters and the sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      md_cnt  <= '0;
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_miss) begin
            state  <= MEM_WAIT;
            to_cnt <= TO_W'(1);
            if (MEM_TIMEOUT == 1) mem_err <= 1'b1;
          end else if (ex_md_start) begin
            state  <= MD_WAIT;
            md_cnt <= MD_INIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state  <= RUN;
            to_cnt <= '0;
          end else begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (to_cnt >= TO_PRE) mem_err <= 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_cnt == '0) begin
            state <= RUN;
          end else begin
            md_cnt <= md_cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_f && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, mul/div, memory wait/timeout, held branch, reset.
// Inputs driven 1ns after posedge, outputs checked at negedge.
// Linear sequence; no unbounded waits on the DUT.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             ex_mem_read, ex_md_start, ex_branch_taken;
  logic             mem_reg_write, wb_reg_write, mem_req, mem_ready;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_m, flush_w;
  logic             md_done, mem_err;
  logic [15:0]      stall_count;
  logic [8:0]       ctl;

  int n_tests = 0;
  int n_fail  = 0;

  // ctl bit order: stall_f stall_d stall_e stall_m flush_d flush_e flush_m flush_w md_done
  localparam logic [8:0] C_IDLE = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110001000;
  localparam logic [8:0] C_BR   = 9'b000011000;
  localparam logic [8:0] C_MD   = 9'b111000100;
  localparam logic [8:0] C_DONE = 9'b000000001;
  localparam logic [8:0] C_MEM  = 9'b111100010;

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, md_done};

  hazard_ctrl #(
    .MD_LATENCY  (4),
    .MEM_TIMEOUT (2),
    .STALL_CNT_W (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_md_start     (ex_md_start),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_reg_write    (wb_reg_write),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .stall_e         (stall_e),
    .stall_m         (stall_m),
    .flush_d         (flush_d),
    .flush_e         (flush_e),
    .flush_m         (flush_m),
    .flush_w         (flush_w),
    .md_done         (md_done),
    .mem_err         (mem_err),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    ex_mem_read = 1'b0; ex_md_start = 1'b0; ex_branch_taken = 1'b0;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Reset with a pending miss and branch: all controls must stay low
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_cnt", 32'(stall_count), 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);

    cyc(); rst = 1'b0; clear_inputs();
    // Forwarding: MEM over WB, then WB, then x0
    mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    ex_rs1 = 5'd5; ex_rs2 = 5'd3;
    @(negedge clk);
    chk("fwd_a_mem", 32'(fwd_a_sel), 32'(2'b10));
    chk("fwd_b_reg", 32'(fwd_b_sel), 32'(2'b00));
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
    mem_reg_write = 1'b0; #1;
    chk("fwd_a_wb", 32'(fwd_a_sel), 32'(2'b01));
    ex_rs1 = 5'd0; #1;
    chk("fwd_a_x0", 32'(fwd_a_sel), 32'(2'b00));
    mem_reg_write = 1'b1; mem_rd = 5'd6; ex_rs1 = 5'd6; ex_rs2 = 5'd5; #1;
    chk("fwd_a_mem2", 32'(fwd_a_sel), 32'(2'b10));
    chk("fwd_b_wb", 32'(fwd_b_sel), 32'(2'b01));

    // Load-use: exactly one bubble
    cyc(); clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    @(negedge clk);
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    cyc(); clear_inputs();
    @(negedge clk);
    chk("lu_after", 32'(ctl), 32'(C_IDLE));
    chk("lu_cnt", 32'(stall_count), 32'd1);
    // Load to x0 never stalls
    cyc(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    @(negedge clk);
    chk("lu_x0", 32'(ctl), 32'(C_IDLE));

    // Branch in RUN
    cyc(); clear_inputs(); ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("br_run", 32'(ctl), 32'(C_BR));

    // Mul/div held: 4 stall cycles, then md_done with the start still high
    cyc(); clear_inputs(); ex_md_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("md_stall%0d", i), 32'(ctl), 32'(C_MD));
      cyc();
    end
    @(negedge clk);
    chk("md_done", 32'(ctl), 32'(C_DONE));
    cyc(); ex_md_start = 1'b0;
    @(negedge clk);
    chk("md_after", 32'(ctl), 32'(C_IDLE));
    chk("md_cnt", 32'(stall_count), 32'd5);

    // Memory wait of 3 cycles with a branch held in EX; timeout of 2 trips mem_err
    cyc(); mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("mw_c1", 32'(ctl), 32'(C_MEM));
    chk("mw_err1", 32'(mem_err), 32'd0);
    cyc();
    @(negedge clk);
    chk("mw_c2", 32'(ctl), 32'(C_MEM));
    chk("mw_err2", 32'(mem_err), 32'd0);
    cyc();
    @(negedge clk);
    chk("mw_c3", 32'(ctl), 32'(C_MEM));
    chk("mw_err3", 32'(mem_err), 32'd1);
    cyc(); mem_ready = 1'b1;
    @(negedge clk);
    chk("mw_release", 32'(ctl), 32'(C_IDLE));
    cyc(); mem_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("mw_branch", 32'(ctl), 32'(C_BR));
    chk("mw_err_sticky", 32'(mem_err), 32'd1);
    chk("mw_cnt", 32'(stall_count), 32'd8);

    // Ready in the request cycle: no stall
    cyc(); clear_inputs(); mem_req = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("mem_hit", 32'(ctl), 32'(C_IDLE));

    // Reset during the second MD_WAIT cycle
    cyc(); clear_inputs(); ex_md_start = 1'b1;
    @(negedge clk);
    chk("mdr_c1", 32'(ctl), 32'(C_MD));
    cyc();
    @(negedge clk);
    chk("mdr_c2", 32'(ctl), 32'(C_MD));
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk("mdr_rst_ctl", 32'(ctl), 32'(C_IDLE));
    chk("mdr_pre_cnt", 32'(stall_count), 32'd10);
    cyc(); rst = 1'b0; ex_md_start = 1'b0;
    @(negedge clk);
    chk("mdr_after", 32'(ctl), 32'(C_IDLE));
    chk("mdr_cnt", 32'(stall_count), 32'd0);
    chk("mdr_err", 32'(mem_err), 32'd0);
    // Branch flush visible immediately proves the FSM is back in RUN
    cyc(); ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("mdr_run", 32'(ctl), 32'(C_BR));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 core. It generates the 2-bit select codes for the two execute-stage operand forwarding muxes. It sequences pipeline stalls and flushes for load-use hazards, taken branches, data-memory wait states and the multi-cycle mul/div unit. It sits beside the datapath in the top-level CPU and owns no datapath registers itself.

## Interface
- MD_LATENCY, 4: total stall cycles for a mul/div op; legal range ≥2.
- MEM_TIMEOUT, 255: MEM_WAIT cycles before `mem_err` is set; legal range ≥1.
- STALL_CNT_W, 16: width of the stall performance counter.

- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  5  decode-stage source registers
- ex_rs1, ex_rs2  in  5  execute-stage source registers
- ex_rd  in  5  execute-stage destination
- ex_mem_read  in  1  EX instruction is a load
- ex_md_start  in  1  EX instruction is mul/div
- ex_branch_taken  in  1  EX resolved a PC redirect
- mem_rd, wb_rd  in  5  MEM/WB destinations
- mem_reg_write, wb_reg_write  in  1  MEM/WB write enables
- mem_req  in  1  MEM stage issues a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects: 00 register file, 01 WB result, 10 MEM ALU result; 11 is never driven
- stall_f, stall_d, stall_e, stall_m  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- flush_d, flush_e, flush_m, flush_w  out  1  insert bubble into IF/ID, ID/EX, EX/MEM, MEM/WB
- md_done  out  1  one-cycle pulse when a mul/div result is valid
- mem_err  out  1  sticky memory-timeout flag
- stall_count  out  STALL_CNT_W  saturating count of cycles with stall_f=1

## Operation
- **Forwarding** is combinational and applies per operand, using rs = ex_rs1 or ex_rs2:
  - Select 10 if mem_reg_write, mem_rd==rs and rs≠0.
  - Otherwise select 01 if wb_reg_write, wb_rd==rs and rs≠0.
  - Otherwise select 00.
  - MEM has priority over WB. The selects are valid in every state.
- **FSM states:** RUN, MEM_WAIT, MD_WAIT. There is a down-counter `md_cnt` and a timeout counter `to_cnt`.
- **RUN, evaluated in priority order:**
  1. mem_req & !mem_ready: assert stall_f/d/e/m and flush_w, then go to MEM_WAIT with to_cnt=1.
  2. ex_md_start: assert stall_f/d/e and flush_m, then go to MD_WAIT with md_cnt=MD_LATENCY-1.
  3. ex_branch_taken: assert flush_d and flush_e.
  4. Load-use (ex_mem_read, ex_rd≠0, ex_rd equals id_rs1 or id_rs2): assert stall_f, stall_d and flush_e.
- **MEM_WAIT:**
  - While !mem_ready: assert stall_f/d/e/m and flush_w, and increment to_cnt (saturating).
  - When to_cnt reaches MEM_TIMEOUT, set mem_err. It stays set until reset, and the wait continues.
  - On mem_ready: drop all stalls and flushes that cycle, then go to RUN.
- **MD_WAIT:**
  - While md_cnt≠0: assert stall_f/d/e and flush_m, and decrement md_cnt.
  - When md_cnt==0: no stall, md_done=1, go to RUN. ex_md_start is ignored in this state.
- **Held events:**
  - Branch flush and load-use are suppressed in MEM_WAIT and MD_WAIT.
  - A branch frozen in EX keeps ex_branch_taken high, so it is applied in the first RUN cycle after release.
- **stall_count** increments on every cycle with stall_f=1 and saturates at all-ones.

## Timing
- **Reset:** state RUN, md_cnt=0, to_cnt=0, mem_err=0, stall_count=0. While rst=1, every stall, flush and md_done output is 0.
- **Reset mid-operation:** the next cycle is RUN with no stall.
- **Outputs:** stall/flush are combinational from registered state and current inputs, with no added latency.
- **Mul/div:** exactly MD_LATENCY stall cycles. The mul/div instruction leaves EX on cycle MD_LATENCY+1, counting the start cycle as 1.
- **Load-use:** exactly one bubble.
- **Memory wait:** N wait cycles with mem_ready low produce N stall cycles.
- **mem_ready already high in the request cycle:** no stall.

## Structure
- Package `hazard_pkg` holds:
  - the `fwd_sel_t` enum: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the `hz_state_t` enum;
  - the register-index width constant (5).
- Sub-module `forward_select` holds the per-operand priority compare and is instantiated twice.
- FSM, counters and stall/flush decode live in `hazard_ctrl`.

## Test plan
- **Forwarding:** mem_rd=5, wb_rd=5, both write-enables set, ex_rs1=5 → fwd_a_sel=10. Drop mem_reg_write → 01. ex_rs1=0 → 00.
- **Load-use:** ex_mem_read=1, ex_rd=7, id_rs2=7 → one cycle of stall_f=stall_d=flush_e=1. The next cycle has no stall. stall_count goes to 1.
- **Mul/div:** MD_LATENCY=4, ex_md_start held → stall_f high for 4 cycles, then md_done=1 for one cycle. A second start arriving on the md_done cycle is ignored.
- **Memory wait:** mem_req=1 with mem_ready low for 3 cycles → stall_f/d/e/m and flush_w high for 3 cycles, released in the mem_ready cycle. MEM_TIMEOUT=2 → mem_err=1 and stays set until rst.
- **Branch during memory wait:** ex_branch_taken=1 while in MEM_WAIT → no flush during the wait. flush_d and flush_e are asserted in the first RUN cycle.
- **Reset mid-mul/div:** rst in the second MD_WAIT cycle → all outputs 0 and state RUN. stall_count=0 after reset.
